fround_pipe: RTL and testbench

//   Parametrised IEEE-754 round-to-integral unit: FLOOR, CEIL, TRUNC or ROUND-NEAREST-EVEN
//   (RNE), selected per operation. Result stays in float format.
//   2-stage pipeline with valid/ready flow control; raises an inexact flag.

---
 rtl/fround_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_fround_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fround_pipe.sv
// ---------------------------------------------------------------------------
// fround_pipe
//
// Round-to-integral unit for IEEE-754 binary formats. Each operation selects
// one of four rounding modes; the result stays in floating-point format and
// an inexact flag reports whether any fraction bits were discarded.
//
// Two register stages with valid/ready flow control:
//   stage 1: classify the operand, clear its fraction bits, and work out the
//            increment and the inexact flag (or pick a special-result code)
//   stage 2: add the increment to the integer significand, handle the carry
//            into the exponent, and pack the result
//
// Handshake: a transfer happens on any clock edge where valid and ready are
// both 1. The pipe advances (adv) whenever the output register is empty or
// its contents are being taken. in_ready is adv itself, so an operand is
// accepted exactly when the whole pipe moves. When adv is 0 every stage
// holds and out_* stay stable.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous reset, active-high; drops every in-flight op
//   in_valid     operand valid
//   in_ready     unit accepts an operand this cycle
//   in_data      operand {sign, exp, man}
//   in_mode      00 RNE, 01 FLOOR (-inf), 10 CEIL (+inf), 11 TRUNC (to 0)
//   out_valid    result valid
//   out_ready    consumer takes the result this cycle
//   out_data     rounded result {sign, exp, man}
//   out_inexact  1 when the result differs from the operand
// ---------------------------------------------------------------------------
module fround_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_inexact
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_HALF = EXP_W'(BIAS - 1);

    localparam logic [1:0] MODE_RNE   = 2'b00;
    localparam logic [1:0] MODE_FLOOR = 2'b01;
    localparam logic [1:0] MODE_CEIL  = 2'b10;
    localparam logic [1:0] MODE_TRUNC = 2'b11;

    // What stage 2 has to do with the stage-1 fields.
    typedef enum logic [1:0] {
        K_ROUND = 2'b00,   // add increment to masked significand
        K_PASS  = 2'b01,   // emit {sign, exp, man} as stored
        K_ZERO  = 2'b10,   // signed zero
        K_ONE   = 2'b11    // signed 1.0
    } kind_t;

    // -----------------------------------------------------------------------
    // Flow control
    // -----------------------------------------------------------------------
    logic w_adv;

    logic r_s1_valid;
    logic r_out_valid;

    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;

    // -----------------------------------------------------------------------
    // Stage 1: classification and fraction analysis
    // -----------------------------------------------------------------------
    logic               w_sign;
    logic [EXP_W-1:0]   w_exp;
    logic [MAN_W-1:0]   w_man;

    // Number of fraction bits F = MAN_W - (exp - BIAS). Only meaningful for
    // the rounding path (1 <= F <= MAN_W); kept signed so out-of-range
    // exponents simply produce empty or full masks.
    int                 w_f;

    logic [MAN_W-1:0]   w_frac_mask;  // bits below the binary point
    logic [MAN_W-1:0]   w_half_mask;  // the bit worth exactly one half
    logic [MAN_W:0]     w_lsb_mask;   // integer LSB within {hidden, man}

    logic               w_frac_nz;
    logic               w_half;
    logic               w_sticky;
    logic               w_lsb;
    logic               w_inc;

    kind_t              w_kind;
    logic [MAN_W-1:0]   w_s1_man;
    logic [MAN_W:0]     w_inc_vec;
    logic               w_s1_inexact;

    always_comb begin
        w_sign = in_data[W-1];
        w_exp  = in_data[W-2:MAN_W];
        w_man  = in_data[MAN_W-1:0];

        w_f = MAN_W + BIAS - int'(w_exp);

        for (int i = 0; i < MAN_W; i++) begin
            w_frac_mask[i] = (i < w_f);
            w_half_mask[i] = (i == w_f - 1);
        end
        for (int i = 0; i <= MAN_W; i++) begin
            w_lsb_mask[i] = (i == w_f);
        end

        w_frac_nz = |(w_man & w_frac_mask);
        w_half    = |(w_man & w_half_mask);
        w_sticky  = |(w_man & w_frac_mask & ~w_half_mask);
        // When F == MAN_W the integer LSB is the hidden bit, hence the
        // leading 1 in the significand.
        w_lsb     = |({1'b1, w_man} & w_lsb_mask);

        case (in_mode)
            MODE_FLOOR: w_inc = w_sign & w_frac_nz;
            MODE_CEIL:  w_inc = ~w_sign & w_frac_nz;
            MODE_TRUNC: w_inc = 1'b0;
            default:    w_inc = w_half & (w_sticky | w_lsb);
        endcase

        // Default: ordinary rounding with 1 <= F <= MAN_W.
        w_kind       = K_ROUND;
        w_s1_man     = w_man & ~w_frac_mask;
        w_inc_vec    = w_inc ? w_lsb_mask : '0;
        w_s1_inexact = w_frac_nz;

        if (w_exp == EXP_ONES) begin
            // NaN is quietened by forcing the mantissa MSB; Inf passes.
            w_kind       = K_PASS;
            w_s1_man     = (w_man != '0) ? (w_man | {1'b1, {(MAN_W-1){1'b0}}}) : w_man;
            w_inc_vec    = '0;
            w_s1_inexact = 1'b0;
        end else if (w_exp == EXP_ZERO) begin
            // Zero and subnormals are treated as zero (DAZ).
            w_kind       = K_ZERO;
            w_inc_vec    = '0;
            w_s1_inexact = 1'b0;
        end else if (w_exp < EXP_BIAS) begin
            // 0 < |x| < 1: result is signed 0 or signed 1.0, always inexact.
            w_inc_vec    = '0;
            w_s1_inexact = 1'b1;
            case (in_mode)
                MODE_FLOOR: w_kind = w_sign ? K_ONE : K_ZERO;
                MODE_CEIL:  w_kind = w_sign ? K_ZERO : K_ONE;
                MODE_TRUNC: w_kind = K_ZERO;
                // An exact 0.5 ties to the even value 0; anything in
                // (0.5, 1) rounds to 1; smaller magnitudes go to 0.
                default:    w_kind = (w_exp == EXP_HALF && w_man != '0) ? K_ONE : K_ZERO;
            endcase
        end else if (w_f <= 0) begin
            // No fraction bits left: value is already integral.
            w_kind       = K_PASS;
            w_s1_man     = w_man;
            w_inc_vec    = '0;
            w_s1_inexact = 1'b0;
        end
    end

    kind_t              r_s1_kind;
    logic               r_s1_sign;
    logic [EXP_W-1:0]   r_s1_exp;
    logic [MAN_W-1:0]   r_s1_man;
    logic [MAN_W:0]     r_s1_inc_vec;
    logic               r_s1_inexact;

    // -----------------------------------------------------------------------
    // Stage 2: increment, carry, pack
    // -----------------------------------------------------------------------
    logic [MAN_W+1:0]   w_sum;
    logic [W-1:0]       w_result;

    always_comb begin
        // One spare bit above the hidden bit catches the carry-out.
        w_sum = {1'b0, 1'b1, r_s1_man} + {1'b0, r_s1_inc_vec};

        case (r_s1_kind)
            K_PASS: w_result = {r_s1_sign, r_s1_exp, r_s1_man};
            K_ZERO: w_result = {r_s1_sign, EXP_ZERO, {MAN_W{1'b0}}};
            K_ONE:  w_result = {r_s1_sign, EXP_BIAS, {MAN_W{1'b0}}};
            default: begin
                // A carry out of the hidden bit means the significand
                // became 2.0: bump the exponent and clear the mantissa.
                // The exponent cannot reach all-ones since E < MAN_W here.
                if (w_sum[MAN_W+1]) begin
                    w_result = {r_s1_sign, r_s1_exp + EXP_W'(1), {MAN_W{1'b0}}};
                end else begin
                    w_result = {r_s1_sign, r_s1_exp, w_sum[MAN_W-1:0]};
                end
            end
        endcase
    end

    logic [W-1:0]       r_out_data;
    logic               r_out_inexact;

    // -----------------------------------------------------------------------
    // Pipeline registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_kind     <= K_ZERO;
            r_s1_sign     <= 1'b0;
            r_s1_exp      <= '0;
            r_s1_man      <= '0;
            r_s1_inc_vec  <= '0;
            r_s1_inexact  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_kind    <= w_kind;
                r_s1_sign    <= w_sign;
                r_s1_exp     <= w_exp;
                r_s1_man     <= w_s1_man;
                r_s1_inc_vec <= w_inc_vec;
                r_s1_inexact <= w_s1_inexact;
            end

            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data    <= w_result;
                r_out_inexact <= r_s1_inexact;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fround_pipe.sv
// ---------------------------------------------------------------------------
// tb_fround_pipe
//
// Bench for fround_pipe at its FP32 defaults. The reference model works on
// the numeric value (integer part, remainder compared against one half) and
// re-encodes the rounded integer, independent of the bit-mask formulation in
// the design.
// ---------------------------------------------------------------------------
module tb_fround_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    int checks;
    int errors;

    fround_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: returns {inexact, result}
    // ------------------------------------------------------------------
    function automatic logic [32:0] ref_round(input logic [31:0] x, input logic [1:0] mode);
        bit          s;
        int          e_fld;
        int          e;
        int          f;
        int          cmp;
        int          p;
        bit          nz;
        bit          up;
        longint      sig;
        longint      ip;
        longint      rem;
        longint      half;
        longint      n;
        logic [31:0] r;
        s     = x[31];
        e_fld = int'(x[30:23]);
        if (e_fld == 255) begin
            if (x[22:0] != 23'd0) return {1'b0, x | 32'h0040_0000};
            return {1'b0, x};
        end
        if (e_fld == 0) return {1'b0, s, 31'd0};
        e = e_fld - 127;
        if (e >= 23) return {1'b0, x};
        sig = 64'h80_0000 + x[22:0];
        if (e < -1) begin
            ip  = 0;
            nz  = 1'b1;
            cmp = -1;
        end else begin
            f    = 23 - e;
            ip   = sig >> f;
            rem  = sig - (ip << f);
            half = 64'd1 << (f - 1);
            nz   = (rem != 0);
            cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
        end
        case (mode)
            2'b00:   up = (cmp > 0) || (cmp == 0 && (ip % 2) == 1);
            2'b01:   up = s && nz;
            2'b10:   up = !s && nz;
            default: up = 1'b0;
        endcase
        n = ip + (up ? 1 : 0);
        if (n == 0) begin
            r = {s, 31'd0};
        end else begin
            p = 0;
            while ((n >> (p + 1)) != 0) p++;
            r = {s, 8'(127 + p), 23'((n << (23 - p)) & 64'h7F_FFFF)};
        end
        return {nz, r};
    endfunction

    function automatic logic [31:0] rand_operand();
        int          k;
        logic [7:0]  e;
        logic [22:0] m;
        k = $urandom_range(0, 15);
        m = 23'($urandom);
        if (k == 0)      e = 8'hFF;
        else if (k == 1) e = 8'h00;
        else if (k <= 4) e = 8'($urandom_range(100, 126));
        else if (k == 5) e = 8'($urandom_range(150, 254));
        else             e = 8'($urandom_range(127, 149));
        // Often clear low bits so exact values and ties show up.
        if ($urandom_range(0, 2) == 0) m = m & (23'h7F_FFFF << $urandom_range(0, 22));
        return {1'($urandom), e, m};
    endfunction

    // ------------------------------------------------------------------
    // Driver: one operand, out_ready held 1; reports latency in cycles
    // ------------------------------------------------------------------
    task automatic send_one(input logic [31:0] d, input logic [1:0] m,
                            output logic [31:0] r, output logic inex, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        @(posedge clk);
        lat  = -1;
        r    = '0;
        inex = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                r    = out_data;
                inex = out_inexact;
                lat  = k;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_data !== 32'd0) begin
            errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data);
        end
        checks++;
        if (out_inexact !== 1'b0) begin
            errors++; $display("FAIL reset_out_inexact got %b exp 0", out_inexact);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] v_in  [0:17];
        logic [1:0]  v_md  [0:17];
        logic [31:0] v_out [0:17];
        logic        v_inx [0:17];
        logic [31:0] r;
        logic        inex;
        int          lat;
        v_in  = '{32'hC0200000, 32'hBFC00000, 32'h40200000, 32'h40600000, 32'h3E99999A,
                  32'hBF333333, 32'h80000001, 32'h4B800000, 32'h7F800001, 32'hFF800000,
                  32'h3F000000, 32'h3F400000, 32'hBF000000, 32'hBE800000, 32'h3FC00000,
                  32'h40490FDB, 32'h40400000, 32'h4AFFFFFF};
        v_md  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
                  2'b11, 2'b01, 2'b00, 2'b10, 2'b01,
                  2'b00, 2'b00, 2'b10, 2'b01, 2'b10,
                  2'b11, 2'b01, 2'b00};
        v_out = '{32'hC0400000, 32'hC0000000, 32'h40000000, 32'h40800000, 32'h3F800000,
                  32'h80000000, 32'h80000000, 32'h4B800000, 32'h7FC00001, 32'hFF800000,
                  32'h00000000, 32'h3F800000, 32'h80000000, 32'hBF800000, 32'h40000000,
                  32'h40400000, 32'h40400000, 32'h4B000000};
        v_inx = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 18; i++) begin
            send_one(v_in[i], v_md[i], r, inex, lat);
            checks++;
            if (lat < 0) begin
                errors++;
                $display("FAIL directed_%0d timeout op %h", i, v_in[i]);
            end else if ({inex, r} !== {v_inx[i], v_out[i]}) begin
                errors++;
                $display("FAIL directed_%0d op %h mode %b got %h/%b exp %h/%b",
                         i, v_in[i], v_md[i], r, inex, v_out[i], v_inx[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] r;
        logic        inex;
        int          lat;
        send_one(32'h40200000, 2'b10, r, inex, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL latency got %0d exp 2", lat);
        end
        checks++;
        if ({inex, r} !== {1'b1, 32'h40400000}) begin
            errors++; $display("FAIL latency_data got %h/%b exp 40400000/1", r, inex);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_out_valid got %b exp 0", out_valid);
        end
    endtask

    // Streams n_ops random operands. With bp=1 out_ready follows 1,0,0,1...
    task automatic test_stream(input int n_ops, input bit bp);
        logic [31:0] ops   [$];
        logic [1:0]  modes [$];
        logic [32:0] exp_q [$];
        logic [32:0] held;
        logic [32:0] got;
        int          sent   = 0;
        int          seen   = 0;
        int          cyc    = 0;
        bit          stalled = 1'b0;
        for (int i = 0; i < n_ops; i++) begin
            ops.push_back(rand_operand());
            modes.push_back(bp ? 2'(i % 4) : 2'($urandom_range(0, 3)));
        end
        held = '0;
        while ((sent < n_ops || exp_q.size() > 0) && cyc < 20 * n_ops + 20) begin
            @(negedge clk);
            out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (sent < n_ops) begin
                in_valid = 1'b1;
                in_data  = ops[sent];
                in_mode  = modes[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== ~(out_valid & ~out_ready)) begin
                errors++;
                $display("FAIL stream_in_ready cyc %0d got %b out_valid %b out_ready %b",
                         cyc, in_ready, out_valid, out_ready);
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {out_inexact, out_data} !== held) begin
                    errors++;
                    $display("FAIL stream_hold cyc %0d got %b/%h exp 1/%h",
                             cyc, out_valid, {out_inexact, out_data}, held);
                end
            end
            if (exp_q.size() >= 2) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bubble cyc %0d got out_valid %b exp 1", cyc, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious cyc %0d got %h exp none", cyc, out_data);
                end else begin
                    got = exp_q.pop_front();
                    seen++;
                    if ({out_inexact, out_data} !== got) begin
                        errors++;
                        $display("FAIL stream_data #%0d got %h/%b exp %h/%b",
                                 seen, out_data, out_inexact, got[31:0], got[32]);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_inexact, out_data};
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_round(in_data, in_mode));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (seen != n_ops) begin
            errors++;
            $display("FAIL stream_count got %0d exp %0d (bp %0d)", seen, n_ops, bp);
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] r;
        logic        inex;
        int          lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h40200000;
        in_mode   = 2'b10;
        @(negedge clk);
        in_data   = 32'hC0200000;
        in_mode   = 2'b01;
        @(negedge clk);
        in_valid  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_flight_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_flight_in_ready got %b exp 1", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rst_flight_ghost cyc %0d got out_valid %b exp 0", k, out_valid);
            end
        end
        send_one(32'h40600000, 2'b00, r, inex, lat);
        checks++;
        if (lat !== 2 || {inex, r} !== {1'b1, 32'h40800000}) begin
            errors++;
            $display("FAIL rst_flight_new got lat %0d %h/%b exp lat 2 40800000/1", lat, r, inex);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_latency();
        test_stream(300, 1'b0);
        test_stream(8, 1'b1);
        test_stream(60, 1'b1);
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
